// File: rtl/rst_pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rst_pulse_gen_if                                                |
// | Brief    : Request/response signals between reset sources and the        |
// |            reset-pulse generator.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface rst_pulse_gen_if;
  logic       btn;
  logic       sw_req;
  logic       sw_ack;
  logic       wdog_kick;
  logic       rst_out;
  logic [1:0] rst_cause;

  modport master (
    output btn,
    output sw_req,
    output wdog_kick,
    input  sw_ack,
    input  rst_out,
    input  rst_cause
  );

  modport slave (
    input  btn,
    input  sw_req,
    input  wdog_kick,
    output sw_ack,
    output rst_out,
    output rst_cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rst_pulse_gen                                                   |
// | Brief    : Merges debounced button, software and optional watchdog reset  |
// |            requests into one fixed-width, rate-limited reset pulse.       |
// |            Watchdog enabled by defining RST_PULSE_WDOG_EN.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rst_pulse_gen #(
  parameter int DEB_CYCLES     = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int WDOG_CYCLES    = 1024
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rst_pulse_gen_if.slave bus
);

  localparam int c_cnt_max = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;
  localparam int c_deb_w   = $clog2(DEB_CYCLES) + 1;

  localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_load  = c_cnt_w'(HOLDOFF_CYCLES - 1);
  localparam logic [c_deb_w-1:0] c_deb_last   = c_deb_w'(DEB_CYCLES - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_pulse = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  localparam logic [1:0] c_cause_none = 2'b00;
  localparam logic [1:0] c_cause_btn  = 2'b01;
  localparam logic [1:0] c_cause_wdog = 2'b10;
  localparam logic [1:0] c_cause_sw   = 2'b11;

  logic               sync1_q;
  logic               btn_s_q;
  logic               deb_state_q, deb_state_d;
  logic [c_deb_w-1:0] deb_cnt_q, deb_cnt_d;
  logic               btn_evt;
  logic               wdog_evt;

  logic [1:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic               rst_out_q;
  logic               sw_ack_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn;
      btn_s_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronized level disagrees with the
  // debounced state; any agreeing cycle restarts the count.
  always_comb begin
    deb_cnt_d   = '0;
    deb_state_d = deb_state_q;
    btn_evt     = 1'b0;
    if (btn_s_q != deb_state_q) begin
      if (deb_cnt_q == c_deb_last) begin
        deb_state_d = btn_s_q;
        btn_evt     = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + c_deb_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_state_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      deb_state_q <= deb_state_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

`ifdef RST_PULSE_WDOG_EN
  localparam int                c_wd_w    = $clog2(WDOG_CYCLES) + 1;
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WDOG_CYCLES - 1);

  logic [c_wd_w-1:0] wd_cnt_q;

  assign wdog_evt = (state_q == c_st_idle) && (wd_cnt_q == c_wd_last) && !bus.wdog_kick;

  always_ff @(posedge clk) begin
    if (rst || bus.wdog_kick || (state_q != c_st_idle)) begin
      wd_cnt_q <= '0;
    end else if (wd_cnt_q != c_wd_last) begin
      wd_cnt_q <= wd_cnt_q + c_wd_w'(1);
    end
  end
`else
  logic unused_wdog_kick;

  assign wdog_evt         = 1'b0;
  assign unused_wdog_kick = bus.wdog_kick;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    sw_ack_w = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (btn_evt || wdog_evt || bus.sw_req) begin
          state_d = c_st_pulse;
          cnt_d   = c_pulse_load;
          if (btn_evt) begin
            cause_d = c_cause_btn;
          end else if (wdog_evt) begin
            cause_d = c_cause_wdog;
          end else begin
            cause_d  = c_cause_sw;
            sw_ack_w = 1'b1;
          end
        end
      end
      c_st_pulse: begin
        if (cnt_q == '0) begin
          state_d = c_st_hold;
          cnt_d   = c_hold_load;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end
      c_st_hold: begin
        if (cnt_q == '0) begin
          state_d = c_st_idle;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_st_idle;
      cnt_q     <= '0;
      cause_q   <= c_cause_none;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      rst_out_q <= (state_d == c_st_pulse);
    end
  end

  assign bus.sw_ack    = sw_ack_w & ~rst;
  assign bus.rst_out   = rst_out_q;
  assign bus.rst_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rst_pulse_gen                                                |
// | Brief    : Self-checking bench for rst_pulse_gen (watchdog cases only     |
// |            when RST_PULSE_WDOG_EN is defined).                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rst_pulse_gen;
  localparam int DEB   = 4;
  localparam int PULSE = 16;
  localparam int HOLD  = 8;
  localparam int WDOG  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rst_pulse_gen_if dut_if ();

  rst_pulse_gen #(
    .DEB_CYCLES    (DEB),
    .PULSE_CYCLES  (PULSE),
    .HOLDOFF_CYCLES(HOLD),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if)
  );

  typedef struct {
    logic [1:0] cause;
    bit         ack;
    int         gap;
  } exp_t;

  typedef struct {
    bit   use_btn;
    bit   bounce;
    bit   use_sw;
    int   sw_delay;
    int   npulse;
    exp_t e1;
    exp_t e2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b1;
  int   hi_cycles = 0;
  bit   kick_auto = 1'b1;
  bit   kick_now = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock step; also plays the requester dropping sw_req after an ack.
  task automatic tick();
    logic a;
    @(negedge clk);
    a = dut_if.sw_ack;
    @(posedge clk);
    #1;
    if (a) dut_if.sw_req = 1'b0;
    dut_if.wdog_kick = kick_auto | kick_now;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", sb_q.size(), 0);
    sb_q.delete();
    repeat (HOLD + 2) tick();
  endtask

  // Pulse monitor: measures each pulse and checks it against the scoreboard.
  initial begin : monitor
    bit         in_pulse;
    bit         ack_prev;
    bit         ack_rise;
    int         width;
    int         cyc;
    int         rise_cyc;
    int         last_rise;
    logic [1:0] cause_rise;
    exp_t       e;
    in_pulse = 0; ack_prev = 0; ack_rise = 0; width = 0; cyc = 0;
    rise_cyc = 0; last_rise = 0; cause_rise = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en || rst) begin
        in_pulse = 0;
        ack_prev = 0;
      end else begin
        if (dut_if.rst_out) begin
          hi_cycles++;
          if (!in_pulse) begin
            in_pulse   = 1;
            width      = 0;
            rise_cyc   = cyc;
            ack_rise   = ack_prev;
            cause_rise = dut_if.rst_cause;
          end
          width++;
        end else if (in_pulse) begin
          in_pulse = 0;
          if (sb_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("pulse_width", width, PULSE);
            chk("pulse_cause", int'(cause_rise), int'(e.cause));
            chk("pulse_ack_before_rise", int'(ack_rise), int'(e.ack));
            if (e.gap != 0) chk("pulse_rise_gap", rise_cyc - last_rise, e.gap);
          end
          last_rise = rise_cyc;
        end
        ack_prev = dut_if.sw_ack;
      end
    end
  end

  task automatic run_vec(input int idx);
    vec_t v;
    int   lat;
    v = vecs[idx];
    sb_q.push_back(v.e1);
    if (v.npulse > 1) sb_q.push_back(v.e2);
    if (v.bounce) begin
      for (int i = 0; i < 10; i++) begin
        dut_if.btn = ~dut_if.btn;
        tick();
      end
    end
    if (v.use_btn) dut_if.btn = 1'b1;
    if (v.use_sw) begin
      repeat (v.sw_delay) tick();
      dut_if.sw_req = 1'b1;
    end
    if (v.use_btn && !v.use_sw) begin
      lat = 0;
      while (!dut_if.rst_out && lat < 40) begin
        tick();
        lat++;
      end
      if (!v.bounce) chk($sformatf("vec%0d_btn_latency", idx), lat, DEB + 2);
    end
    if (v.use_btn) begin
      repeat (20) tick();
      dut_if.btn = 1'b0;
    end
    wait_drain(200);
    repeat (DEB + 4) tick();
  endtask

  initial begin : watchdog_timer
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int h0;
    int lat;
    dut_if.btn       = 1'b0;
    dut_if.sw_req    = 1'b0;
    dut_if.wdog_kick = 1'b1;
    rst              = 1'b1;

    // {use_btn, bounce, use_sw, sw_delay, npulse, first pulse, second pulse}
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0,       1, '{2'b11, 1'b1, 0}, '{2'b00, 1'b0, 0}};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 0,       1, '{2'b01, 1'b0, 0}, '{2'b00, 1'b0, 0}};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 0,       1, '{2'b01, 1'b0, 0}, '{2'b00, 1'b0, 0}};
    vecs[3] = '{1'b1, 1'b0, 1'b1, DEB + 1, 2, '{2'b01, 1'b0, 0},
                '{2'b11, 1'b1, PULSE + HOLD + 1}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rst_out", int'(dut_if.rst_out), 0);
    chk("rst_sw_ack", int'(dut_if.sw_ack), 0);
    chk("rst_cause", int'(dut_if.rst_cause), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rst_out", int'(dut_if.rst_out), 0);
    chk("post_rst_cause", int'(dut_if.rst_cause), 0);
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // Button press landing in HOLD is dropped.
    sb_q.push_back('{2'b11, 1'b1, 0});
    dut_if.sw_req = 1'b1;
    n = 0;
    while (!dut_if.rst_out && n < 50) begin tick(); n++; end
    while (dut_if.rst_out && n < 100) begin tick(); n++; end
    chk("hold_seq_timeout", int'(n >= 100), 0);
    dut_if.btn = 1'b1;
    h0 = hi_cycles;
    repeat (40) tick();
    chk("hold_press_rst_out_cycles", hi_cycles - h0, 0);
    chk("hold_press_cause", int'(dut_if.rst_cause), 3);
    dut_if.btn = 1'b0;
    repeat (DEB + 4) tick();
    chk("hold_press_sb_empty", sb_q.size(), 0);

    // Reset mid-pulse, then a full software pulse.
    mon_en = 1'b0;
    dut_if.sw_req = 1'b1;
    n = 0;
    while (!dut_if.rst_out && n < 50) begin tick(); n++; end
    repeat (4) tick();
    chk("midrst_in_pulse", int'(dut_if.rst_out), 1);
    rst = 1'b1;
    tick();
    chk("midrst_rst_out", int'(dut_if.rst_out), 0);
    chk("midrst_cause", int'(dut_if.rst_cause), 0);
    chk("midrst_sw_ack", int'(dut_if.sw_ack), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("midrst_after_rst_out", int'(dut_if.rst_out), 0);
    chk("midrst_after_cause", int'(dut_if.rst_cause), 0);
    mon_en = 1'b1;
    sb_q.push_back('{2'b11, 1'b1, 0});
    dut_if.sw_req = 1'b1;
    wait_drain(100);

`ifdef RST_PULSE_WDOG_EN
    kick_auto = 1'b0;
    h0 = hi_cycles;
    for (int k = 0; k < 5; k++) begin
      kick_now = 1'b1;
      tick();
      kick_now = 1'b0;
      repeat (19) tick();
    end
    chk("wdog_kicked_no_pulse", hi_cycles - h0, 0);
    sb_q.push_back('{2'b10, 1'b0, 0});
    kick_now = 1'b1;
    tick();
    kick_now = 1'b0;
    lat = 0;
    while (!dut_if.rst_out && lat < 100) begin tick(); lat++; end
    chk("wdog_latency", lat, WDOG + 1);
    kick_auto = 1'b1;
    wait_drain(100);
`else
    lat = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rst_pulse_gen.md
# rst_pulse_gen

Reset-request generator that drives the asynchronous reset input of the downstream reset synchronizers. It merges three reset sources: a bouncy external push-button, a software request handshake, and an optional watchdog. The merged request becomes a single clean, minimum-width, registered reset pulse with a recorded cause, and further pulses are rate-limited by a hold-off window.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized-button cycles needed to accept a press or release (≥1).
- `PULSE_CYCLES`, default 16: width of `rst_out` in clk cycles (≥1).
- `HOLDOFF_CYCLES`, default 8: cycles after the pulse during which no new pulse may start (≥1).
- `WDOG_CYCLES`, default 1024: watchdog timeout in clk cycles (≥2; used only with `RST_PULSE_WDOG_EN`).
- `clk`, input, 1: single clock; all logic on posedge.
- `rst`, input, 1: reset; **synchronous, active-high**.
- `btn`, input, 1: raw push-button, asynchronous, active-high, bouncy.
- `sw_req`, input, 1: software reset request level; held high until `sw_ack`.
- `sw_ack`, output, 1: one-cycle acknowledge of `sw_req`.
- `wdog_kick`, input, 1: watchdog service strobe. Ignored without `RST_PULSE_WDOG_EN`.
- `rst_out`, output, 1: registered reset pulse to the downstream synchronizers, active-high.
- `rst_cause`, output, 2: cause of the most recent pulse. 00 none, 01 button, 10 watchdog, 11 software.

## Operation
- Button path:
  - `btn` passes through a 2-flop synchronizer to `btn_s`.
  - A debounce counter tracks a stable level. `btn_s` high for DEB_CYCLES consecutive cycles while the debounced state is low sets the debounced state high and emits a one-cycle `btn_evt`.
  - The debounced state returns low only after `btn_s` is low for DEB_CYCLES consecutive cycles.
  - A single press produces exactly one `btn_evt`, however long it is held.
- FSM states are IDLE, PULSE and HOLD.
- IDLE:
  - `rst_out`=0.
  - If any request is present (`btn_evt`, `wdog_evt`, `sw_req`), go to PULSE.
  - Load the down-counter with PULSE_CYCLES.
  - Latch `rst_cause` with priority button > watchdog > software.
  - If software wins, assert `sw_ack` for that one cycle.
- PULSE:
  - `rst_out`=1.
  - When the counter expires, go to HOLD and load HOLDOFF_CYCLES.
- HOLD:
  - `rst_out`=0.
  - When the counter expires, go to IDLE.
- Requests while in PULSE or HOLD:
  - `btn_evt` and `wdog_evt` are dropped, not queued.
  - `sw_req` is a level, so it stays pending and is serviced on the next IDLE cycle.
  - A `sw_req` that loses arbitration in IDLE is not acked and remains pending.
- `sw_ack` is asserted only in the IDLE→PULSE cycle for a software-cause pulse. The requester must drop `sw_req` on the cycle after `sw_ack`.
- `rst_cause` holds its value until the next pulse starts.
- Counter widths are `$clog2` of the relevant maximum plus 1. There is no wrap-around: counters saturate or reload only as described above.

## Timing
- Reset values while `rst` is high and on the first cycle after it:
  - State IDLE.
  - `rst_out`=0, `sw_ack`=0, `rst_cause`=00.
  - Debounced state low; debounce and watchdog counters 0; synchronizer flops 0.
- `rst` mid-pulse aborts at the next edge: `rst_out`=0 and all state returns to the reset values above.
- Request sampled in IDLE at edge N:
  - `rst_out` is high from N+1 through N+PULSE_CYCLES.
  - `rst_out` is low at N+PULSE_CYCLES+1.
  - IDLE is re-entered at N+1+PULSE_CYCLES+HOLDOFF_CYCLES; a request is accepted at that edge.
- `sw_ack` is high in the cycle ending at edge N (combinational from state and request, registered outputs elsewhere). `rst_cause` updates at N+1.
- Button latency: 2 synchronizer cycles plus DEB_CYCLES to `btn_evt`.
- Simultaneous button and software requests in IDLE: button wins, `sw_ack` stays 0, and the software request is serviced after HOLD.

## Configuration
- `RST_PULSE_WDOG_EN` defined:
  - The watchdog counter increments every cycle in IDLE.
  - It clears on `wdog_kick` and in PULSE and HOLD.
  - When it reaches WDOG_CYCLES-1 without a kick it emits a one-cycle `wdog_evt`.
  - A kick in the same cycle as the terminal count suppresses the event.
- `RST_PULSE_WDOG_EN` undefined:
  - No watchdog counter is instantiated.
  - `wdog_evt` is tied to 0, so `rst_cause` never takes the value 10.
  - `wdog_kick` is unused.

## Test plan
- Bouncy press (btn toggling every cycle for 10 cycles, then held high for 20), DEB_CYCLES=4 → exactly one pulse, `rst_out` high for 16 cycles, `rst_cause`=01.
- `sw_req` raised in IDLE → `sw_ack` for 1 cycle, `rst_out` high 16 cycles starting the next cycle, `rst_cause`=11.
- `btn_evt` and `sw_req` in the same IDLE cycle → button pulse first, no ack; after 16+8 cycles, `sw_ack` and a second pulse with `rst_cause`=11.
- Button press during HOLD → no pulse; `rst_out` stays 0 and `rst_cause` is unchanged.
- `RST_PULSE_WDOG_EN` with WDOG_CYCLES=32:
  - Kicking every 20 cycles → no pulse.
  - Stopping the kicks → pulse 32 cycles after the last kick, `rst_cause`=10.
- `rst` asserted at pulse cycle 5 → `rst_out`=0 next cycle and `rst_cause`=00; a new `sw_req` after `rst` drops → a full 16-cycle pulse.
